// File: rtl/fetch_pc_gen_pkg.sv
// Shared definitions for the IF-stage fetch PC generator: ExcCodes, reset PC and FSM encoding.
package fetch_pc_gen_pkg;

  typedef enum logic {
    StRun  = 1'b0,
    StHalt = 1'b1
  } fetch_st_e;

  localparam logic [4:0]  ExcAdel = 5'h04;
  localparam logic [31:0] ResetPc = 32'hBFC00000;

endpackage

// File: rtl/fetch_slot_mask.sv
// Per-slot valid mask for a fetch group: from the entry slot upward, or a single delay-slot entry.
module fetch_slot_mask #(
  parameter int unsigned FETCH_WIDTH = 4,
  localparam int unsigned SLOT_W = $clog2(FETCH_WIDTH)
) (
  input  logic [SLOT_W-1:0]      slot_i,
  input  logic                   ds_i,
  output logic [FETCH_WIDTH-1:0] mask_o
);

  localparam logic [FETCH_WIDTH-1:0] OneHot0 = {{(FETCH_WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    mask_o = {FETCH_WIDTH{1'b1}} << slot_i;
    if (ds_i) begin
      mask_o = OneHot0 << slot_i;
    end
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// IF-stage fetch address generator: selects the next group PC from redirects or the predictor
// and issues group-aligned index requests to the I-Cache.
module fetch_pc_gen
  import fetch_pc_gen_pkg::*;
#(
  parameter int unsigned       FETCH_WIDTH = 4,
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       IDX_HI      = 11,
  parameter logic [ADDR_W-1:0] RESET_PC    = ResetPc,
  parameter logic [4:0]        ADEL_CODE   = ExcAdel,
  localparam int unsigned      OFS         = $clog2(FETCH_WIDTH) + 2
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   inst_req,
  output logic [IDX_HI-OFS:0]    inst_index,
  input  logic                   inst_index_ok,
  input  logic                   stop_fetch_i,
  input  logic [ADDR_W-1:0]      pred_pc_i,
  input  logic                   pred_need_ds_i,
  input  logic                   bsc_flush_i,
  input  logic                   sba_flush_i,
  input  logic [ADDR_W-1:0]      sba_dest_i,
  input  logic                   exc_flush_i,
  input  logic [ADDR_W-1:0]      exc_dest_i,
  output logic [ADDR_W-1:0]      vaddr_o,
  output logic [ADDR_W-1:0]      last_vaddr_o,
  output logic [FETCH_WIDTH-1:0] inst_enable_o,
  output logic                   need_ds_o,
  output logic                   has_exc_o,
  output logic [4:0]             exc_code_o
);

  localparam int unsigned GRP_W = ADDR_W - OFS;
  localparam logic [GRP_W-1:0] GrpOne = {{(GRP_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] pc_q;
  logic              ds_q;
  fetch_st_e         st_q;
  logic              accept;
  logic [GRP_W-1:0]  grp;

  assign grp        = pc_q[ADDR_W-1:OFS];
  assign inst_req   = rst && (st_q == StRun) && !stop_fetch_i;
  assign accept     = inst_req && inst_index_ok;
  assign inst_index = pc_q[IDX_HI:OFS];

  // Low two bits are kept so the misalignment travels with the group.
  assign vaddr_o      = {grp, {(OFS-2){1'b0}}, pc_q[1:0]};
  assign last_vaddr_o = {grp - GrpOne, {(OFS-2){1'b0}}, pc_q[1:0]};
  assign need_ds_o    = ds_q;
  assign has_exc_o    = |pc_q[1:0];
  assign exc_code_o   = ADEL_CODE;

  fetch_slot_mask #(
    .FETCH_WIDTH(FETCH_WIDTH)
  ) u_slot_mask (
    .slot_i(pc_q[OFS-1:2]),
    .ds_i  (ds_q),
    .mask_o(inst_enable_o)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q <= RESET_PC;
      ds_q <= 1'b0;
      st_q <= StRun;
    end else if (exc_flush_i) begin
      pc_q <= exc_dest_i;
      ds_q <= 1'b0;
      st_q <= StRun;
    end else if (sba_flush_i) begin
      pc_q <= sba_dest_i;
      ds_q <= 1'b0;
      st_q <= StRun;
    end else if (bsc_flush_i) begin
      pc_q <= pred_pc_i;
      ds_q <= pred_need_ds_i;
      st_q <= StRun;
    end else if (accept) begin
      // A misaligned group is still issued so the exception reaches WB; then wait for redirect.
      if (has_exc_o) begin
        st_q <= StHalt;
      end else begin
        pc_q <= pred_pc_i;
        ds_q <= pred_need_ds_i;
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen: a 4-wide instance for the main flows and an 8-wide one for
// mask/alignment corner cases.
module tb_fetch_pc_gen;

  logic        clk;
  logic        rst;

  logic        inst_req;
  logic [7:0]  inst_index;
  logic        inst_index_ok;
  logic        stop_fetch;
  logic [31:0] pred_pc;
  logic        pred_need_ds;
  logic        bsc_flush;
  logic        sba_flush;
  logic [31:0] sba_dest;
  logic        exc_flush;
  logic [31:0] exc_dest;
  logic [31:0] vaddr;
  logic [31:0] last_vaddr;
  logic [3:0]  inst_enable;
  logic        need_ds;
  logic        has_exc;
  logic [4:0]  exc_code;

  logic        inst_req8;
  logic [6:0]  inst_index8;
  logic        exc_flush8;
  logic [31:0] exc_dest8;
  logic [31:0] vaddr8;
  logic [31:0] last_vaddr8;
  logic [7:0]  inst_enable8;
  logic        need_ds8;
  logic        has_exc8;
  logic [4:0]  exc_code8;

  int n_total;
  int n_bad;

  fetch_pc_gen #(
    .FETCH_WIDTH(4)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .inst_req      (inst_req),
    .inst_index    (inst_index),
    .inst_index_ok (inst_index_ok),
    .stop_fetch_i  (stop_fetch),
    .pred_pc_i     (pred_pc),
    .pred_need_ds_i(pred_need_ds),
    .bsc_flush_i   (bsc_flush),
    .sba_flush_i   (sba_flush),
    .sba_dest_i    (sba_dest),
    .exc_flush_i   (exc_flush),
    .exc_dest_i    (exc_dest),
    .vaddr_o       (vaddr),
    .last_vaddr_o  (last_vaddr),
    .inst_enable_o (inst_enable),
    .need_ds_o     (need_ds),
    .has_exc_o     (has_exc),
    .exc_code_o    (exc_code)
  );

  fetch_pc_gen #(
    .FETCH_WIDTH(8)
  ) u_dut8 (
    .clk           (clk),
    .rst           (rst),
    .inst_req      (inst_req8),
    .inst_index    (inst_index8),
    .inst_index_ok (1'b0),
    .stop_fetch_i  (1'b1),
    .pred_pc_i     (32'h0000_0000),
    .pred_need_ds_i(1'b0),
    .bsc_flush_i   (1'b0),
    .sba_flush_i   (1'b0),
    .sba_dest_i    (32'h0000_0000),
    .exc_flush_i   (exc_flush8),
    .exc_dest_i    (exc_dest8),
    .vaddr_o       (vaddr8),
    .last_vaddr_o  (last_vaddr8),
    .inst_enable_o (inst_enable8),
    .need_ds_o     (need_ds8),
    .has_exc_o     (has_exc8),
    .exc_code_o    (exc_code8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_total       = 0;
    n_bad         = 0;
    rst           = 1'b0;
    inst_index_ok = 1'b1;
    stop_fetch    = 1'b0;
    pred_pc       = 32'hBFC00010;
    pred_need_ds  = 1'b0;
    bsc_flush     = 1'b0;
    sba_flush     = 1'b0;
    sba_dest      = 32'h0;
    exc_flush     = 1'b0;
    exc_dest      = 32'h0;
    exc_flush8    = 1'b0;
    exc_dest8     = 32'h0;

    repeat (2) step();
    check_eq("rst_req_low", {31'b0, inst_req}, 32'h0);
    check_eq("rst_vaddr", vaddr, 32'hBFC00000);

    rst = 1'b1;
    #1;
    check_eq("run_req", {31'b0, inst_req}, 32'h1);
    check_eq("rst_enable", {28'b0, inst_enable}, 32'hF);
    check_eq("rst_has_exc", {31'b0, has_exc}, 32'h0);
    check_eq("rst_need_ds", {31'b0, need_ds}, 32'h0);
    check_eq("rst_index", {24'b0, inst_index}, 32'h00);

    step();
    check_eq("seq_vaddr", vaddr, 32'hBFC00010);
    check_eq("seq_enable", {28'b0, inst_enable}, 32'hF);
    check_eq("seq_index", {24'b0, inst_index}, 32'h01);

    pred_pc = 32'hBFC00028;
    step();
    check_eq("mid_vaddr", vaddr, 32'hBFC00020);
    check_eq("mid_enable", {28'b0, inst_enable}, 32'hC);
    check_eq("mid_last_vaddr", last_vaddr, 32'hBFC00010);

    pred_need_ds = 1'b1;
    step();
    check_eq("ds_enable", {28'b0, inst_enable}, 32'h4);
    check_eq("ds_need_ds", {31'b0, need_ds}, 32'h1);

    pred_need_ds = 1'b0;
    exc_flush    = 1'b1;
    exc_dest     = 32'h80000180;
    sba_flush    = 1'b1;
    sba_dest     = 32'hBFC00300;
    step();
    exc_flush = 1'b0;
    sba_flush = 1'b0;
    check_eq("exc_vaddr", vaddr, 32'h80000180);
    check_eq("exc_need_ds", {31'b0, need_ds}, 32'h0);
    check_eq("exc_enable", {28'b0, inst_enable}, 32'hF);

    sba_flush = 1'b1;
    sba_dest  = 32'hBFC00022;
    step();
    sba_flush = 1'b0;
    check_eq("adel_vaddr", vaddr, 32'hBFC00022);
    check_eq("adel_has_exc", {31'b0, has_exc}, 32'h1);
    check_eq("adel_code", {27'b0, exc_code}, 32'h04);
    check_eq("adel_req", {31'b0, inst_req}, 32'h1);

    step();
    for (int i = 0; i < 5; i++) begin
      check_eq("halt_req", {31'b0, inst_req}, 32'h0);
      step();
    end
    check_eq("halt_vaddr", vaddr, 32'hBFC00022);

    sba_flush = 1'b1;
    sba_dest  = 32'hBFC00100;
    step();
    sba_flush = 1'b0;
    pred_pc   = 32'hBFC00200;
    check_eq("resume_vaddr", vaddr, 32'hBFC00100);
    check_eq("resume_req", {31'b0, inst_req}, 32'h1);
    check_eq("resume_has_exc", {31'b0, has_exc}, 32'h0);

    stop_fetch = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_eq("stop_req", {31'b0, inst_req}, 32'h0);
      step();
      check_eq("stop_vaddr", vaddr, 32'hBFC00100);
    end

    stop_fetch    = 1'b0;
    inst_index_ok = 1'b0;
    #1;
    check_eq("wait_req", {31'b0, inst_req}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("wait_index", {24'b0, inst_index}, 32'h10);
    end

    bsc_flush = 1'b1;
    pred_pc   = 32'hBFC00344;
    step();
    bsc_flush = 1'b0;
    check_eq("bsc_vaddr", vaddr, 32'hBFC00340);
    check_eq("bsc_enable", {28'b0, inst_enable}, 32'hE);

    inst_index_ok = 1'b1;
    pred_pc       = 32'hBFC00400;
    step();
    check_eq("accept_vaddr", vaddr, 32'hBFC00400);

    rst = 1'b0;
    #1;
    check_eq("mid_rst_req", {31'b0, inst_req}, 32'h0);
    step();
    check_eq("mid_rst_vaddr", vaddr, 32'hBFC00000);
    rst = 1'b1;

    exc_flush8 = 1'b1;
    exc_dest8  = 32'h00000014;
    step();
    check_eq("w8_vaddr", vaddr8, 32'h00000000);
    check_eq("w8_enable", {24'b0, inst_enable8}, 32'hE0);
    check_eq("w8_last_vaddr", last_vaddr8, 32'hFFFFFFE0);

    exc_dest8 = 32'h0000000C;
    step();
    exc_flush8 = 1'b0;
    check_eq("w8_enable_s3", {24'b0, inst_enable8}, 32'hF8);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
